// File: rtl/fir_polyphase_tx_iq.sv
// Dual-channel (I/Q) polyphase transmit pulse-shaping filter for 1-bit symbol
// streams. The phase counter is internal. Coefficients live in a double-buffered
// bank: writes go to the shadow bank, and a swap request copies shadow to active
// at the next symbol boundary.
module fir_polyphase_tx_iq #(
    parameter int OS         = 4,
    parameter int N_SYM      = 6,
    parameter int NB_COEFF   = 8,
    parameter int NBF_COEFF  = 6,
    parameter int NB_OUTPUT  = 8,
    parameter int NBF_OUTPUT = 6
) (
    input  logic                         clock,
    input  logic                         i_reset,
    input  logic                         i_enable,
    input  logic                         i_data_i,
    input  logic                         i_data_q,
    input  logic                         i_coef_we,
    input  logic [$clog2(OS*N_SYM)-1:0]  i_coef_addr,
    input  logic signed [NB_COEFF-1:0]   i_coef_data,
    input  logic                         i_coef_swap,
    output logic                         o_sym_req,
    output logic                         o_swap_pending,
    output logic [$clog2(OS)-1:0]        o_phase,
    output logic                         o_valid,
    output logic signed [NB_OUTPUT-1:0]  o_out_fir_i,
    output logic signed [NB_OUTPUT-1:0]  o_out_fir_q
);

    localparam int N_TAP   = OS * N_SYM;
    localparam int NB_ADD  = NB_COEFF + $clog2(N_SYM) + 1;
    localparam int NB_PH   = $clog2(OS);
    localparam int NB_ADDR = $clog2(N_TAP);
    localparam int NB_SIDX = $clog2(N_SYM);
    localparam int DROP    = NBF_COEFF - NBF_OUTPUT;

    localparam logic [NB_PH-1:0]         PH_LAST = NB_PH'(OS - 1);
    localparam logic signed [NB_ADD-1:0] SAT_HI  = NB_ADD'(2 ** (NB_OUTPUT - 1) - 1);
    localparam logic signed [NB_ADD-1:0] SAT_LO  = NB_ADD'(-(2 ** (NB_OUTPUT - 1)));

    logic [NB_PH-1:0]            phase;
    logic [N_SYM-1:0]            sr_i;
    logic [N_SYM-1:0]            sr_q;
    logic signed [NB_COEFF-1:0]  coef_shadow [N_TAP];
    logic signed [NB_COEFF-1:0]  coef_active [N_TAP];
    logic                        swap_pending;
    logic                        sym_boundary;
    logic                        apply_swap;
    logic signed [NB_ADD-1:0]    sum_i;
    logic signed [NB_ADD-1:0]    sum_q;
    logic signed [NB_ADD-1:0]    tap_ext;

    // Truncate the extra fractional bits (floor), then clamp to the output range.
    function automatic logic [NB_OUTPUT-1:0] quantise(input logic signed [NB_ADD-1:0] s);
        logic signed [NB_ADD-1:0] t;
        logic signed [NB_ADD-1:0] c;
        t = s >>> DROP;
        if (t > SAT_HI)
            c = SAT_HI;
        else if (t < SAT_LO)
            c = SAT_LO;
        else
            c = t;
        return c[NB_OUTPUT-1:0];
    endfunction

    assign sym_boundary   = i_enable && (phase == PH_LAST);
    // A swap pulse landing on the boundary edge itself is honoured at that edge.
    assign apply_swap     = sym_boundary && (swap_pending || i_coef_swap);
    assign o_sym_req      = sym_boundary;
    assign o_swap_pending = swap_pending;
    assign o_phase        = phase;

    // Phase counter: wraps naturally since OS is a power of two.
    always_ff @(posedge clock) begin
        if (i_reset)
            phase <= '0;
        else if (i_enable)
            phase <= phase + 1'b1;
    end

    // Symbol shift registers: bit 0 holds the newest symbol.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            sr_i <= '0;
            sr_q <= '0;
        end else if (sym_boundary) begin
            sr_i <= {sr_i[N_SYM-2:0], i_data_i};
            sr_q <= {sr_q[N_SYM-2:0], i_data_q};
        end
    end

    // Coefficient banks and swap handshake; the copy reads pre-write shadow contents.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            for (int unsigned t = 0; t < N_TAP; t++) begin
                coef_shadow[NB_ADDR'(t)] <= '0;
                coef_active[NB_ADDR'(t)] <= '0;
            end
            swap_pending <= 1'b0;
        end else begin
            if (apply_swap) begin
                for (int unsigned t = 0; t < N_TAP; t++)
                    coef_active[NB_ADDR'(t)] <= coef_shadow[NB_ADDR'(t)];
            end
            if (i_coef_we && (int'(i_coef_addr) < N_TAP))
                coef_shadow[i_coef_addr] <= i_coef_data;
            if (apply_swap)
                swap_pending <= 1'b0;
            else if (i_coef_swap)
                swap_pending <= 1'b1;
        end
    end

    // Polyphase sum: each symbol adds or subtracts its sign-extended tap for this phase.
    always_comb begin
        sum_i   = '0;
        sum_q   = '0;
        tap_ext = '0;
        for (int unsigned k = 0; k < N_SYM; k++) begin
            tap_ext = NB_ADD'(coef_active[NB_ADDR'(k * OS) + NB_ADDR'(phase)]);
            sum_i   = sr_i[NB_SIDX'(k)] ? (sum_i - tap_ext) : (sum_i + tap_ext);
            sum_q   = sr_q[NB_SIDX'(k)] ? (sum_q - tap_ext) : (sum_q + tap_ext);
        end
    end

    // Output register: one sample per enabled clock, valid tracks enable.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            o_valid     <= 1'b0;
            o_out_fir_i <= '0;
            o_out_fir_q <= '0;
        end else begin
            o_valid <= i_enable;
            if (i_enable) begin
                o_out_fir_i <= quantise(sum_i);
                o_out_fir_q <= quantise(sum_q);
            end
        end
    end

endmodule

// File: tb/tb_fir_polyphase_tx_iq.sv
// Directed self-checking bench for fir_polyphase_tx_iq (default parameters).
module tb_fir_polyphase_tx_iq;

    logic        clock = 1'b0;
    logic        rst   = 1'b1;
    logic        en    = 1'b1;
    logic        di    = 1'b0;
    logic        dq    = 1'b0;
    logic        we    = 1'b0;
    logic [4:0]  addr  = '0;
    logic [7:0]  cdata = '0;
    logic        swap  = 1'b0;
    logic        sym_req;
    logic        pending;
    logic [1:0]  phase;
    logic        valid;
    logic [7:0]  out_i;
    logic [7:0]  out_q;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int exp_ph = 0;

    fir_polyphase_tx_iq #(
        .OS(4), .N_SYM(6), .NB_COEFF(8), .NBF_COEFF(6), .NB_OUTPUT(8), .NBF_OUTPUT(6)
    ) dut (
        .clock(clock), .i_reset(rst), .i_enable(en), .i_data_i(di), .i_data_q(dq),
        .i_coef_we(we), .i_coef_addr(addr), .i_coef_data(cdata), .i_coef_swap(swap),
        .o_sym_req(sym_req), .o_swap_pending(pending), .o_phase(phase), .o_valid(valid),
        .o_out_fir_i(out_i), .o_out_fir_q(out_q)
    );

    always #5 clock = ~clock;

    task automatic tick();
        if (rst)
            exp_ph = 0;
        else if (en)
            exp_ph = (exp_ph + 1) % 4;
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic run_to_phase(input int p);
        for (int n = 0; n < 8 && exp_ph != p; n++) tick();
        check("run_to_phase", 16'(phase), 16'(p));
    endtask

    task automatic write_coef(input logic [4:0] a, input logic [7:0] d);
        we = 1'b1; addr = a; cdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic pulse_swap();
        swap = 1'b1;
        tick();
        swap = 1'b0;
    endtask

    initial begin
        // 1: reset with enable high, then symbol-request cadence
        ticks(3);
        check("rst_phase", 16'(phase), 16'd0);
        check("rst_valid", 16'(valid), 16'd0);
        check("rst_out_i", 16'(out_i), 16'h00);
        check("rst_out_q", 16'(out_q), 16'h00);
        check("rst_pending", 16'(pending), 16'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("cadence_phase", 16'(phase), 16'(exp_ph));
            check("cadence_sym_req", 16'(sym_req), (exp_ph == 3) ? 16'd1 : 16'd0);
        end

        // 2: single tap h[0]=0x40, I symbol 1 then 0
        en = 1'b0;
        write_coef(5'd0, 8'h40);
        pulse_swap();
        check("t2_pending_set", 16'(pending), 16'd1);
        check("t2_valid_idle", 16'(valid), 16'd0);
        en = 1'b1;
        tick();
        check("t2_valid_resume", 16'(valid), 16'd1);
        run_to_phase(0);
        check("t2_pending_clear", 16'(pending), 16'd0);
        di = 1'b1;
        ticks(4);
        di = 1'b0;
        tick();
        check("t2_i_ph0_neg", 16'(out_i), 16'h00C0);
        check("t2_q_ph0_pos", 16'(out_q), 16'h0040);
        tick();
        check("t2_i_ph1", 16'(out_i), 16'h0000);
        ticks(2);
        check("t2_i_ph3", 16'(out_i), 16'h0000);
        tick();
        check("t2_i_ph0_pos", 16'(out_i), 16'h0040);
        check("t2_q_ph0_again", 16'(out_q), 16'h0040);

        // 3: all phase-0 taps 0x7F -> sum +/-762 saturates
        en = 1'b0;
        for (int k = 0; k < 6; k++) write_coef(5'(4 * k), 8'h7F);
        pulse_swap();
        check("t3_pending_set", 16'(pending), 16'd1);
        di = 1'b0; dq = 1'b0; en = 1'b1;
        run_to_phase(0);
        ticks(20);
        tick();
        check("t3_i_sat_hi", 16'(out_i), 16'h007F);
        check("t3_q_sat_hi", 16'(out_q), 16'h007F);
        tick();
        check("t3_i_ph1_zero", 16'(out_i), 16'h0000);
        di = 1'b1; dq = 1'b1;
        run_to_phase(0);
        ticks(20);
        tick();
        check("t3_i_sat_lo", 16'(out_i), 16'h0080);
        check("t3_q_sat_lo", 16'(out_q), 16'h0080);

        // 4: h[0]=-128; negating it gives +128 which saturates
        en = 1'b0;
        write_coef(5'd0, 8'h80);
        for (int k = 1; k < 6; k++) write_coef(5'(4 * k), 8'h00);
        pulse_swap();
        en = 1'b1; di = 1'b1; dq = 1'b0;
        run_to_phase(0);
        tick();
        check("t4_i_neg_min", 16'(out_i), 16'h007F);
        check("t4_q_min", 16'(out_q), 16'h0080);

        // 5: live reload: B = {h0=0x20, h1=0x30}, write on boundary edge stays in shadow
        we = 1'b1; addr = 5'd0; cdata = 8'h20; swap = 1'b1;
        tick();
        check("t5_pending_ph2", 16'(pending), 16'd1);
        addr = 5'd1; cdata = 8'h30;
        tick();
        check("t5_pending_ph3", 16'(pending), 16'd1);
        check("t5_sym_req_ph3", 16'(sym_req), 16'd1);
        addr = 5'd0; cdata = 8'h10; swap = 1'b0;
        tick();
        we = 1'b0;
        check("t5_pending_applied", 16'(pending), 16'd0);
        check("t5_phase0", 16'(phase), 16'd0);
        tick();
        check("t5_i_ph0_B", 16'(out_i), 16'h00E0);
        check("t5_q_ph0_B", 16'(out_q), 16'h0020);
        check("t5_pending_absorbed", 16'(pending), 16'd0);
        tick();
        check("t5_i_ph1_B", 16'(out_i), 16'h00D0);
        check("t5_q_ph1_B", 16'(out_q), 16'h0030);

        // 6: enable low for 5 clocks at phase 2, then reset at phase 3
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t6_hold_phase", 16'(phase), 16'd2);
            check("t6_hold_valid", 16'(valid), 16'd0);
            check("t6_hold_i", 16'(out_i), 16'h00D0);
            check("t6_hold_q", 16'(out_q), 16'h0030);
        end
        en = 1'b1; swap = 1'b1;
        tick();
        swap = 1'b0;
        check("t6_resume_phase", 16'(phase), 16'd3);
        check("t6_resume_valid", 16'(valid), 16'd1);
        check("t6_resume_i_ph2", 16'(out_i), 16'h0000);
        check("t6_pending_pre_rst", 16'(pending), 16'd1);
        rst = 1'b1;
        tick();
        check("t6_rst_phase", 16'(phase), 16'd0);
        check("t6_rst_valid", 16'(valid), 16'd0);
        check("t6_rst_pending", 16'(pending), 16'd0);
        check("t6_rst_out_i", 16'(out_i), 16'h0000);
        rst = 1'b0;
        tick();
        check("t6_post_rst_i", 16'(out_i), 16'h0000);
        check("t6_post_rst_q", 16'(out_q), 16'h0000);
        check("t6_post_rst_phase", 16'(phase), 16'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
